// File: rtl/cipher_dma_master_if.sv
// AHB-lite style initiator/target signal bundle used between the cipher DMA
// master and the system bus (single NONSEQ word transfers only).
interface cipher_dma_master_if;
    logic        HBUSREQ;
    logic        HGRANT;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic [1:0]  HRESP;

    modport master (
        output HBUSREQ, HADDR, HTRANS, HWRITE, HSIZE, HWDATA,
        input  HGRANT, HRDATA, HREADY, HRESP
    );

    modport slave (
        input  HBUSREQ, HADDR, HTRANS, HWRITE, HSIZE, HWDATA,
        output HGRANT, HRDATA, HREADY, HRESP
    );
endinterface

// File: rtl/cipher_dma_master.sv
// Bus master for the encryption engine: reads plaintext words, XORs them with a
// 64-bit LFSR keystream and writes the ciphertext back, one word at a time.
//
// state | meaning
// IDLE  | waiting for a start_encrypt[0] rising edge
// REQ   | bus requested, waiting for grant with HREADY (also re-arbitration after RETRY/SPLIT)
// RD_A  | read address phase for word i
// RD_D  | read data phase, waiting for HREADY
// WR_A  | write address phase for word i
// WR_D  | write data phase, HWDATA held, waiting for HREADY
// FIN   | done pulse, bus released
module cipher_dma_master #(
    parameter logic [31:0] MAX_WORDS = 32'hFFFF_FFFF
) (
    input  logic                       HCLK,
    input  logic                       HRESET,
    input  logic [31:0]                start_encrypt,
    input  logic [31:0]                plain_addr,
    input  logic [31:0]                frame_size,
    input  logic [31:0]                cipher_addr,
    input  logic [31:0]                seed_lsw,
    input  logic [31:0]                seed_msw,
    output logic                       done,
    output logic                       busy,
    output logic                       error,
    cipher_dma_master_if.master        bus
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_RD_A,
        ST_RD_D,
        ST_WR_A,
        ST_WR_D,
        ST_FIN
    } state_t;

    localparam logic [1:0] HT_IDLE   = 2'b00;
    localparam logic [1:0] HT_NONSEQ = 2'b10;
    localparam logic [1:0] RESP_OK   = 2'b00;
    localparam logic [1:0] RESP_ERR  = 2'b01;

    state_t      state;
    logic        start_q;
    logic [31:0] plain_base;
    logic [31:0] cipher_base;
    logic [31:0] count;
    logic [31:0] idx;
    logic [63:0] lfsr;
    logic        wr_pend;

    logic        hbusreq;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [31:0] hwdata;

    logic        start_edge;
    logic [32:0] clamp_diff;
    logic [31:0] size_clamped;
    logic [63:0] seed;
    logic [63:0] lfsr_next;
    logic [31:0] idx_next;
    logic [31:0] rd_addr;
    logic [31:0] wr_addr;
    logic [31:0] rd_addr_next;
    logic        unused_bits;

    assign start_edge   = start_encrypt[0] & ~start_q;
    // Borrow out of MAX_WORDS - frame_size means the request exceeds the clamp.
    assign clamp_diff   = {1'b0, MAX_WORDS} - {1'b0, frame_size};
    assign size_clamped = clamp_diff[32] ? MAX_WORDS : frame_size;
    assign seed         = {seed_msw, seed_lsw};
    assign lfsr_next    = {lfsr[62:0], lfsr[63] ^ lfsr[62] ^ lfsr[60] ^ lfsr[59]};
    assign idx_next     = idx + 32'd1;
    assign rd_addr      = plain_base + {idx[29:0], 2'b00};
    assign wr_addr      = cipher_base + {idx[29:0], 2'b00};
    assign rd_addr_next = plain_base + {idx_next[29:0], 2'b00};
    assign unused_bits  = ^{start_encrypt[31:1], plain_addr[1:0], cipher_addr[1:0]};

    assign bus.HBUSREQ = hbusreq;
    assign bus.HADDR   = haddr;
    assign bus.HTRANS  = htrans;
    assign bus.HWRITE  = hwrite;
    assign bus.HSIZE   = 3'b010;
    assign bus.HWDATA  = hwdata;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state       <= ST_IDLE;
            start_q     <= 1'b0;
            plain_base  <= 32'd0;
            cipher_base <= 32'd0;
            count       <= 32'd0;
            idx         <= 32'd0;
            lfsr        <= 64'd0;
            wr_pend     <= 1'b0;
            done        <= 1'b0;
            busy        <= 1'b0;
            error       <= 1'b0;
            hbusreq     <= 1'b0;
            haddr       <= 32'd0;
            htrans      <= HT_IDLE;
            hwrite      <= 1'b0;
            hwdata      <= 32'd0;
        end else begin
            start_q <= start_encrypt[0];
            done    <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    busy <= 1'b0;
                    if (start_edge) begin
                        plain_base  <= {plain_addr[31:2], 2'b00};
                        cipher_base <= {cipher_addr[31:2], 2'b00};
                        count       <= size_clamped;
                        lfsr        <= (seed == 64'd0) ? 64'd1 : seed;
                        idx         <= 32'd0;
                        wr_pend     <= 1'b0;
                        error       <= 1'b0;
                        busy        <= 1'b1;
                        if (size_clamped == 32'd0) begin
                            state <= ST_FIN;
                        end else begin
                            hbusreq <= 1'b1;
                            state   <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    if (bus.HGRANT && bus.HREADY) begin
                        htrans <= HT_NONSEQ;
                        hwrite <= wr_pend;
                        haddr  <= wr_pend ? wr_addr : rd_addr;
                        state  <= wr_pend ? ST_WR_A : ST_RD_A;
                    end
                end
                ST_RD_A, ST_WR_A: begin
                    if (!bus.HGRANT) begin
                        // Grant lost during the address phase: re-arbitrate and redo it.
                        htrans  <= HT_IDLE;
                        wr_pend <= (state == ST_WR_A);
                        state   <= ST_REQ;
                    end else if (bus.HREADY) begin
                        htrans <= HT_IDLE;
                        state  <= (state == ST_RD_A) ? ST_RD_D : ST_WR_D;
                    end
                end
                ST_RD_D: begin
                    if (bus.HREADY) begin
                        case (bus.HRESP)
                            RESP_OK: begin
                                hwdata <= bus.HRDATA ^ lfsr[31:0];
                                haddr  <= wr_addr;
                                htrans <= HT_NONSEQ;
                                hwrite <= 1'b1;
                                state  <= ST_WR_A;
                            end
                            RESP_ERR: begin
                                error   <= 1'b1;
                                hbusreq <= 1'b0;
                                state   <= ST_FIN;
                            end
                            default: begin
                                wr_pend <= 1'b0;
                                state   <= ST_REQ;
                            end
                        endcase
                    end
                end
                ST_WR_D: begin
                    if (bus.HREADY) begin
                        case (bus.HRESP)
                            RESP_OK: begin
                                lfsr <= lfsr_next;
                                idx  <= idx_next;
                                if (idx_next == count) begin
                                    hbusreq <= 1'b0;
                                    hwrite  <= 1'b0;
                                    state   <= ST_FIN;
                                end else if (bus.HGRANT) begin
                                    haddr  <= rd_addr_next;
                                    htrans <= HT_NONSEQ;
                                    hwrite <= 1'b0;
                                    state  <= ST_RD_A;
                                end else begin
                                    wr_pend <= 1'b0;
                                    hwrite  <= 1'b0;
                                    state   <= ST_REQ;
                                end
                            end
                            RESP_ERR: begin
                                error   <= 1'b1;
                                hbusreq <= 1'b0;
                                state   <= ST_FIN;
                            end
                            default: begin
                                // hwdata is left untouched so the retried write carries identical data.
                                wr_pend <= 1'b1;
                                state   <= ST_REQ;
                            end
                        endcase
                    end
                end
                ST_FIN: begin
                    done    <= 1'b1;
                    hbusreq <= 1'b0;
                    htrans  <= HT_IDLE;
                    state   <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cipher_dma_master.sv
// Directed bench for cipher_dma_master with a word-addressed memory slave model
// that supports wait states plus ERROR/RETRY injection.
module tb_cipher_dma_master;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic [31:0] start_encrypt;
    logic [31:0] plain_addr;
    logic [31:0] frame_size;
    logic [31:0] cipher_addr;
    logic [31:0] seed_lsw;
    logic [31:0] seed_msw;
    logic        done;
    logic        busy;
    logic        error;

    cipher_dma_master_if bus ();

    cipher_dma_master dut (
        .HCLK          (HCLK),
        .HRESET        (HRESET),
        .start_encrypt (start_encrypt),
        .plain_addr    (plain_addr),
        .frame_size    (frame_size),
        .cipher_addr   (cipher_addr),
        .seed_lsw      (seed_lsw),
        .seed_msw      (seed_msw),
        .done          (done),
        .busy          (busy),
        .error         (error),
        .bus           (bus)
    );

    always #5 HCLK = ~HCLK;

    int nvec = 0;
    int nerr = 0;

    logic [31:0] mem [0:1023];
    int          wait_states = 0;
    int          err_rd_n    = 0;
    int          retry_wr_n  = 0;

    int          cyc = 0;
    int          n_done, n_nonseq, n_rd_addr, n_wr_addr, n_rd_dp, n_wr_dp, n_wr_log, hw_unstable;
    int          rd_cyc [16];
    logic [31:0] rd_addr_log [16];
    logic [31:0] wr_log_addr [16];
    logic [31:0] wr_log_data [16];

    logic        dp_active = 1'b0;
    logic        dp_write;
    logic        dp_seen;
    logic [31:0] dp_addr;
    logic [31:0] dp_wdata;
    int          dp_wait;
    logic [1:0]  resp;

    // Slave model evaluates on the falling edge so the DUT samples settled inputs.
    always @(negedge HCLK) begin
        cyc++;
        if (done) n_done++;
        if (HRESET) begin
            dp_active  = 1'b0;
            bus.HREADY = 1'b1;
            bus.HRESP  = 2'b00;
            bus.HRDATA = 32'd0;
        end else if (dp_active) begin
            if (dp_write) begin
                if (!dp_seen) begin
                    dp_wdata = bus.HWDATA;
                    dp_seen  = 1'b1;
                end else if (bus.HWDATA !== dp_wdata) begin
                    hw_unstable++;
                end
            end
            if (dp_wait > 0) begin
                bus.HREADY = 1'b0;
                bus.HRESP  = 2'b00;
                dp_wait--;
            end else begin
                resp = 2'b00;
                if (dp_write) begin
                    n_wr_dp++;
                    if (n_wr_dp == retry_wr_n) resp = 2'b10;
                    if (n_wr_log < 16) begin
                        wr_log_addr[n_wr_log] = dp_addr;
                        wr_log_data[n_wr_log] = bus.HWDATA;
                        n_wr_log++;
                    end
                    if (resp == 2'b00) mem[dp_addr[11:2]] = bus.HWDATA;
                end else begin
                    n_rd_dp++;
                    if (n_rd_dp == err_rd_n) resp = 2'b01;
                    bus.HRDATA = mem[dp_addr[11:2]];
                end
                bus.HREADY = 1'b1;
                bus.HRESP  = resp;
                dp_active  = 1'b0;
            end
        end else begin
            bus.HREADY = 1'b1;
            bus.HRESP  = 2'b00;
            if (bus.HTRANS == 2'b10) begin
                n_nonseq++;
                dp_active = 1'b1;
                dp_addr   = bus.HADDR;
                dp_write  = bus.HWRITE;
                dp_wait   = wait_states;
                dp_seen   = 1'b0;
                if (bus.HWRITE) begin
                    n_wr_addr++;
                end else begin
                    if (n_rd_addr < 16) begin
                        rd_cyc[n_rd_addr]      = cyc;
                        rd_addr_log[n_rd_addr] = bus.HADDR;
                    end
                    n_rd_addr++;
                end
            end
        end
    end

    task automatic tick();
        @(negedge HCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr_stats();
        n_done = 0; n_nonseq = 0; n_rd_addr = 0; n_wr_addr = 0;
        n_rd_dp = 0; n_wr_dp = 0; n_wr_log = 0; hw_unstable = 0;
        err_rd_n = 0; retry_wr_n = 0;
    endtask

    task automatic start_frame(input logic [31:0] p, input logic [31:0] c, input logic [31:0] n,
                               input logic [31:0] slo, input logic [31:0] shi);
        plain_addr = p; cipher_addr = c; frame_size = n; seed_lsw = slo; seed_msw = shi;
        start_encrypt = 32'h1;
        tick();
        start_encrypt = 32'h0;
    endtask

    // Leaves the caller in the cycle where done is high.
    task automatic wait_done(input string tag, input int budget);
        int base;
        int k;
        base = n_done;
        k = 0;
        while (n_done == base && k < budget) begin
            tick();
            k++;
        end
        chk(tag, 64'(n_done != base), 64'd1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_done"},    64'(done),        64'd0);
        chk({tag, "_busy"},    64'(busy),        64'd0);
        chk({tag, "_error"},   64'(error),       64'd0);
        chk({tag, "_hbusreq"}, 64'(bus.HBUSREQ), 64'd0);
        chk({tag, "_haddr"},   64'(bus.HADDR),   64'd0);
        chk({tag, "_htrans"},  64'(bus.HTRANS),  64'd0);
        chk({tag, "_hwrite"},  64'(bus.HWRITE),  64'd0);
        chk({tag, "_hwdata"},  64'(bus.HWDATA),  64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed no summary expected summary before time limit");
        $fatal(1, "bench time limit expired");
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'hDEAD_BEEF;
        bus.HGRANT = 1'b1;
        HRESET = 1'b1;
        start_encrypt = 32'd0; plain_addr = 32'd0; frame_size = 32'd0;
        cipher_addr = 32'd0; seed_lsw = 32'd0; seed_msw = 32'd0;
        clr_stats();
        repeat (3) tick();
        chk_reset_outputs("reset");
        chk("reset_hsize", 64'(bus.HSIZE), 64'd2);
        HRESET = 1'b0;
        tick();

        // Basic frame, seed 1, zero wait states.
        clr_stats();
        mem[32'h100 >> 2] = 32'h1111_1111;
        mem[32'h104 >> 2] = 32'h2222_2222;
        mem[32'h108 >> 2] = 32'h3333_3333;
        start_frame(32'h100, 32'h200, 32'd3, 32'd1, 32'd0);
        chk("t1_busy_after_start", 64'(busy), 64'd1);
        wait_done("t1_done_seen", 100);
        chk("t1_busy_at_done", 64'(busy), 64'd1);
        tick();
        chk("t1_busy_drops", 64'(busy), 64'd0);
        repeat (3) tick();
        chk("t1_done_once", 64'(n_done), 64'd1);
        chk("t1_w0", 64'(mem[32'h200 >> 2]), 64'h1111_1110);
        chk("t1_w1", 64'(mem[32'h204 >> 2]), 64'h2222_2220);
        chk("t1_w2", 64'(mem[32'h208 >> 2]), 64'h3333_3337);
        chk("t1_error", 64'(error), 64'd0);
        chk("t1_word_latency", 64'(rd_cyc[1] - rd_cyc[0]), 64'd4);

        // Zero-length frame: done two cycles after the start edge, no bus activity.
        clr_stats();
        start_frame(32'h100, 32'h200, 32'd0, 32'd1, 32'd0);
        chk("t2_done_early", 64'(done), 64'd0);
        chk("t2_busy", 64'(busy), 64'd1);
        tick();
        chk("t2_done_pulse", 64'(done), 64'd1);
        tick();
        chk("t2_done_low", 64'(done), 64'd0);
        chk("t2_busy_low", 64'(busy), 64'd0);
        chk("t2_no_nonseq", 64'(n_nonseq), 64'd0);

        // Two wait states per data phase; an extra start edge mid-frame is ignored.
        clr_stats();
        wait_states = 2;
        mem[32'h300 >> 2] = 32'hA5A5_A5A5;
        mem[32'h304 >> 2] = 32'h0F0F_0F0F;
        start_frame(32'h300, 32'h400, 32'd2, 32'h0000_00FF, 32'd0);
        repeat (3) tick();
        start_encrypt = 32'h1;
        tick();
        start_encrypt = 32'h0;
        wait_done("t3_done_seen", 100);
        repeat (6) tick();
        chk("t3_w0", 64'(mem[32'h400 >> 2]), 64'hA5A5_A55A);
        chk("t3_w1", 64'(mem[32'h404 >> 2]), 64'h0F0F_0EF1);
        chk("t3_hwdata_stable", 64'(hw_unstable), 64'd0);
        chk("t3_word_latency", 64'(rd_cyc[1] - rd_cyc[0]), 64'd8);
        chk("t3_no_requeue_done", 64'(n_done), 64'd1);
        chk("t3_no_requeue_busy", 64'(busy), 64'd0);
        wait_states = 0;

        // ERROR on the second read.
        clr_stats();
        err_rd_n = 2;
        for (int i = 0; i < 4; i++) mem[(32'h500 >> 2) + i] = 32'h0000_0010 * (i + 1);
        start_frame(32'h500, 32'h600, 32'd4, 32'd1, 32'd0);
        wait_done("t4_done_seen", 100);
        tick();
        chk("t4_error_set", 64'(error), 64'd1);
        chk("t4_one_write", 64'(n_wr_addr), 64'd1);
        chk("t4_w0", 64'(mem[32'h600 >> 2]), 64'h0000_0011);
        chk("t4_w1_untouched", 64'(mem[32'h604 >> 2]), 64'hDEAD_BEEF);
        start_frame(32'h500, 32'h600, 32'd0, 32'd1, 32'd0);
        chk("t4_error_cleared", 64'(error), 64'd0);
        repeat (3) tick();

        // RETRY on the first write; LFSR taps exercised by bit 63 of the seed.
        clr_stats();
        retry_wr_n = 1;
        mem[32'h700 >> 2] = 32'h1000_0000;
        mem[32'h704 >> 2] = 32'h2000_0000;
        start_frame(32'h700, 32'h780, 32'd2, 32'd3, 32'h8000_0000);
        wait_done("t5_done_seen", 100);
        tick();
        chk("t5_write_phases", 64'(n_wr_dp), 64'd3);
        chk("t5_retry_addr", 64'(wr_log_addr[1]), 64'h780);
        chk("t5_retry_data", 64'(wr_log_data[1]), 64'h1000_0003);
        chk("t5_w0", 64'(mem[32'h780 >> 2]), 64'h1000_0003);
        chk("t5_w1", 64'(mem[32'h784 >> 2]), 64'h2000_0007);

        // All-zero seed behaves as seed 1.
        clr_stats();
        mem[32'h800 >> 2] = 32'h5555_5555;
        start_frame(32'h800, 32'h840, 32'd1, 32'd0, 32'd0);
        wait_done("t6_done_seen", 100);
        tick();
        chk("t6_w0", 64'(mem[32'h840 >> 2]), 64'h5555_5554);

        // Address wrap past the top of memory; low address bits ignored.
        clr_stats();
        mem[32'h3FF] = 32'hCAFE_F00D;
        mem[0]       = 32'h0BAD_BEEF;
        start_frame(32'hFFFF_FFFE, 32'h903, 32'd2, 32'd1, 32'd0);
        wait_done("t7_done_seen", 100);
        tick();
        chk("t7_rd_addr0", 64'(rd_addr_log[0]), 64'hFFFF_FFFC);
        chk("t7_rd_addr1", 64'(rd_addr_log[1]), 64'h0);
        chk("t7_w0", 64'(mem[32'h900 >> 2]), 64'hCAFE_F00C);
        chk("t7_w1", 64'(mem[32'h904 >> 2]), 64'h0BAD_BEED);

        // Reset asserted during WR_D.
        clr_stats();
        wait_states = 2;
        mem[32'hA00 >> 2] = 32'h1234_5678;
        mem[32'hA04 >> 2] = 32'h9ABC_DEF0;
        start_frame(32'hA00, 32'hA80, 32'd2, 32'd1, 32'd0);
        begin
            int k;
            k = 0;
            while (!(bus.HWRITE && bus.HTRANS == 2'b00 && bus.HBUSREQ) && k < 50) begin
                tick();
                k++;
            end
            chk("t8_reached_wr_d", 64'(k < 50), 64'd1);
        end
        HRESET = 1'b1;
        tick();
        chk_reset_outputs("t8_reset");
        HRESET = 1'b0;
        wait_states = 0;
        repeat (5) tick();
        chk("t8_no_done", 64'(n_done), 64'd0);
        chk("t8_idle_busy", 64'(busy), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
